nco_phase_gen: RTL and testbench

Numerically controlled phase generator that drives the sine look-up table's `phase` input. Accumulates a frequency control word (FCW) once per sample strobe, adds a static phase offset, supports glitch-free FCW updates and a linear up-chirp sweep, and emits a sample-valid flag delayed to match the registered LUT output. It sits between the control/register block and the sine LUT in the waveform-generation path.

---
 rtl/nco_pkg.sv | 15 +
 rtl/valid_delay.sv | 37 +++
 rtl/nco_phase_gen.sv | 149 ++++++++++++++
 tb/tb_nco_phase_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// nco_pkg
//   Shared types and defaults for the NCO phase generator.
//   nco_state_t       : STOPPED / RUN / SWEEP control states
//   NCO_PHASE_WIDTH   : default accumulator / FCW / phase width
package nco_pkg;

  localparam int NCO_PHASE_WIDTH = 32;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUN     = 2'd1,
    SWEEP   = 2'd2
  } nco_state_t;

endpackage : nco_pkg

// File: rtl/valid_delay.sv
// valid_delay
//   Fixed-depth shift register that delays a single-bit valid flag so it
//   lines up with a registered downstream pipeline (the sine LUT).
//   clk  : clock
//   rst  : synchronous active-high reset, clears every stage
//   d    : flag in
//   q    : flag delayed by exactly DEPTH cycles
module valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr_q;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) sr_q[gi] <= 1'b0;
          else     sr_q[gi] <= d;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (rst) sr_q[gi] <= 1'b0;
          else     sr_q[gi] <= sr_q[gi-1];
        end
      end
    end
  endgenerate

  assign q = sr_q[DEPTH-1];

endmodule : valid_delay

// File: rtl/nco_phase_gen.sv
// nco_phase_gen
//   Numerically controlled phase generator feeding the sine LUT phase input.
//   Accumulates the active FCW on every accepted sample strobe, adds a phase
//   offset on output, supports glitch-free FCW reloads and a linear up-chirp.
//   clk, rst       : clock, synchronous active-high reset
//   run            : level, 1 = generate, 0 = stop and hold
//   sample_en      : one-cycle sample-rate strobe
//   fcw_in/fcw_load: new FCW and its capture pulse (into shadow register)
//   phase_offset   : static offset added to the accumulator on output
//   sweep_start/step/stop : chirp control, step/stop latched at start
//   phase, phase_valid, wrap : registered phase word, new-sample flag, carry
//   sample_valid   : phase_valid delayed LUT_LATENCY cycles
//   sweep_active   : in SWEEP; sweep_done : one-cycle completion pulse
module nco_phase_gen
  import nco_pkg::*;
#(
  parameter int PHASE_WIDTH = NCO_PHASE_WIDTH,
  parameter int LUT_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   sample_en,
  input  logic [PHASE_WIDTH-1:0] fcw_in,
  input  logic                   fcw_load,
  input  logic [PHASE_WIDTH-1:0] phase_offset,
  input  logic                   sweep_start,
  input  logic [PHASE_WIDTH-1:0] sweep_step,
  input  logic [PHASE_WIDTH-1:0] sweep_stop,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic                   phase_valid,
  output logic                   wrap,
  output logic                   sample_valid,
  output logic                   sweep_active,
  output logic                   sweep_done
);

  localparam int W = PHASE_WIDTH;

  nco_state_t state_q;
  logic [W-1:0] acc_q;
  logic [W-1:0] fcw_active_q;
  logic [W-1:0] fcw_shadow_q;
  logic [W-1:0] step_q;
  logic [W-1:0] stop_q;
  logic [W-1:0] phase_q;
  logic         phase_valid_q;
  logic         wrap_q;
  logic         sweep_done_q;

  logic         accept_d;
  logic [W:0]   acc_sum_d;
  logic [W:0]   sweep_sum_d;
  logic         sweep_end_d;
  logic [W-1:0] shadow_d;

  // A strobe only counts when already generating and run is still high on
  // this edge, so dropping run blocks a coincident strobe.
  assign accept_d    = sample_en && run && (state_q != STOPPED);
  assign acc_sum_d   = {1'b0, acc_q} + {1'b0, fcw_active_q};
  // One extra bit so a step that overflows the FCW still ends the sweep.
  assign sweep_sum_d = {1'b0, fcw_active_q} + {1'b0, step_q};
  assign sweep_end_d = (sweep_sum_d >= {1'b0, stop_q});
  // Shadow value as seen after this edge; forwarding it lets a load that
  // coincides with a strobe take effect from the very next strobe.
  assign shadow_d    = fcw_load ? fcw_in : fcw_shadow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= STOPPED;
      acc_q         <= '0;
      fcw_active_q  <= '0;
      fcw_shadow_q  <= '0;
      step_q        <= '0;
      stop_q        <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
      sweep_done_q  <= 1'b0;
    end else begin
      phase_valid_q <= accept_d;
      wrap_q        <= accept_d & acc_sum_d[W];
      sweep_done_q  <= 1'b0;

      if (accept_d) begin
        phase_q <= acc_q + phase_offset;
        acc_q   <= acc_sum_d[W-1:0];
      end

      if (fcw_load) fcw_shadow_q <= fcw_in;

      case (state_q)
        STOPPED: begin
          // Nothing is accumulating, so the active FCW can follow the
          // shadow freely; generation then starts at the loaded frequency.
          fcw_active_q <= shadow_d;
          if (run) state_q <= RUN;
        end

        RUN: begin
          if (!run) begin
            state_q <= STOPPED;
          end else begin
            if (sample_en) fcw_active_q <= shadow_d;
            if (sweep_start) begin
              step_q  <= sweep_step;
              stop_q  <= sweep_stop;
              state_q <= SWEEP;
            end
          end
        end

        SWEEP: begin
          if (!run) begin
            state_q <= STOPPED;
          end else if (sample_en) begin
            if (sweep_end_d) begin
              // Stop value wins over any load made during the sweep.
              fcw_active_q <= stop_q;
              fcw_shadow_q <= stop_q;
              sweep_done_q <= 1'b1;
              state_q      <= RUN;
            end else begin
              fcw_active_q <= sweep_sum_d[W-1:0];
            end
          end
        end

        default: state_q <= STOPPED;
      endcase
    end
  end

  valid_delay #(
    .DEPTH(LUT_LATENCY)
  ) u_valid_delay (
    .clk(clk),
    .rst(rst),
    .d  (phase_valid_q),
    .q  (sample_valid)
  );

  assign phase        = phase_q;
  assign phase_valid  = phase_valid_q;
  assign wrap         = wrap_q;
  assign sweep_done   = sweep_done_q;
  assign sweep_active = (state_q == SWEEP);

endmodule : nco_phase_gen

// File: tb/tb_nco_phase_gen.sv
// tb_nco_phase_gen
//   Directed-vector bench for nco_phase_gen with hand-computed expectations.
module tb_nco_phase_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        sample_en;
  logic [31:0] fcw_in;
  logic        fcw_load;
  logic [31:0] phase_offset;
  logic        sweep_start;
  logic [31:0] sweep_step;
  logic [31:0] sweep_stop;
  logic [31:0] phase;
  logic        phase_valid;
  logic        wrap;
  logic        sample_valid;
  logic        sweep_active;
  logic        sweep_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nco_phase_gen #(
    .PHASE_WIDTH(32),
    .LUT_LATENCY(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .sample_en   (sample_en),
    .fcw_in      (fcw_in),
    .fcw_load    (fcw_load),
    .phase_offset(phase_offset),
    .sweep_start (sweep_start),
    .sweep_step  (sweep_step),
    .sweep_stop  (sweep_stop),
    .phase       (phase),
    .phase_valid (phase_valid),
    .wrap        (wrap),
    .sample_valid(sample_valid),
    .sweep_active(sweep_active),
    .sweep_done  (sweep_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; sample_en = 1'b0; fcw_in = '0; fcw_load = 1'b0;
    phase_offset = '0; sweep_start = 1'b0; sweep_step = '0; sweep_stop = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic load_fcw(input logic [31:0] v);
    fcw_in = v; fcw_load = 1'b1;
    cyc();
    fcw_load = 1'b0;
  endtask

  // One strobe (optionally with a coincident FCW load), then one idle cycle.
  task automatic strobe(input string tag, input logic [31:0] exp_phase,
                        input logic exp_wrap, input logic exp_done,
                        input logic exp_act, input logic ld, input logic [31:0] ld_val);
    sample_en = 1'b1;
    if (ld) begin fcw_in = ld_val; fcw_load = 1'b1; end
    cyc();
    sample_en = 1'b0; fcw_load = 1'b0;
    chk({tag, ".valid"}, 64'(phase_valid), 64'd1);
    chk({tag, ".phase"}, 64'(phase), 64'(exp_phase));
    chk({tag, ".wrap"},  64'(wrap), 64'(exp_wrap));
    chk({tag, ".done"},  64'(sweep_done), 64'(exp_done));
    chk({tag, ".active"}, 64'(sweep_active), 64'(exp_act));
    chk({tag, ".sv_lag"}, 64'(sample_valid), 64'd0);
    cyc();
    chk({tag, ".sv"}, 64'(sample_valid), 64'd1);
    chk({tag, ".idle"}, 64'(phase_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] t1_ph [5];
    logic        t1_wr [5];
    logic [31:0] t2_ph [3];
    t1_ph = '{32'h0, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0};
    t1_wr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    t2_ph = '{32'h8000_0000, 32'h9000_0000, 32'hA000_0000};

    // Reset state
    do_reset();
    chk("rst.phase", 64'(phase), 64'd0);
    chk("rst.valid", 64'(phase_valid), 64'd0);
    chk("rst.sv", 64'(sample_valid), 64'd0);
    chk("rst.active", 64'(sweep_active), 64'd0);
    chk("rst.wrap", 64'(wrap), 64'd0);

    // Quarter-turn FCW, wrap on fourth strobe
    load_fcw(32'h4000_0000);
    run = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++)
      strobe($sformatf("t1.s%0d", i), t1_ph[i], t1_wr[i], 1'b0, 1'b0, 1'b0, '0);

    // Phase offset
    do_reset();
    load_fcw(32'h1000_0000);
    phase_offset = 32'h8000_0000;
    run = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++)
      strobe($sformatf("t2.s%0d", i), t2_ph[i], 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // FCW load coincident with strobe 2
    do_reset();
    load_fcw(32'h100);
    run = 1'b1;
    cyc();
    strobe("t3.s0", 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, '0);
    strobe("t3.s1", 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
    strobe("t3.s2", 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    strobe("t3.s3", 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Sweep 0x100 -> 0x200, 0x300, 0x350 (clamped)
    do_reset();
    load_fcw(32'h100);
    run = 1'b1;
    cyc();
    sweep_step = 32'h100; sweep_stop = 32'h350; sweep_start = 1'b1;
    cyc();
    sweep_start = 1'b0;
    chk("t4.active", 64'(sweep_active), 64'd1);
    strobe("t4.s0", 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, '0);
    strobe("t4.s1", 32'h100, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    strobe("t4.s2", 32'h300, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    strobe("t4.s3", 32'h600, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    strobe("t4.s4", 32'h950, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // run=0 mid-sweep with coincident strobe
    do_reset();
    load_fcw(32'h100);
    run = 1'b1;
    cyc();
    sweep_step = 32'h10; sweep_stop = 32'h1000; sweep_start = 1'b1;
    cyc();
    sweep_start = 1'b0;
    strobe("t5.s0", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    run = 1'b0; sample_en = 1'b1;
    cyc();
    sample_en = 1'b0;
    chk("t5.stop.valid", 64'(phase_valid), 64'd0);
    chk("t5.stop.done", 64'(sweep_done), 64'd0);
    chk("t5.stop.active", 64'(sweep_active), 64'd0);
    run = 1'b1;
    cyc();
    strobe("t5.resume", 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Reset during sweep with back-to-back strobes in flight
    do_reset();
    load_fcw(32'h100);
    run = 1'b1;
    cyc();
    sweep_step = 32'h100; sweep_stop = 32'h1000; sweep_start = 1'b1;
    cyc();
    sweep_start = 1'b0;
    sample_en = 1'b1;
    cyc();
    chk("t6.pre.valid", 64'(phase_valid), 64'd1);
    cyc();
    chk("t6.pre.phase", 64'(phase), 64'h100);
    rst = 1'b1;
    cyc();
    chk("t6.rst.phase", 64'(phase), 64'd0);
    chk("t6.rst.valid", 64'(phase_valid), 64'd0);
    chk("t6.rst.sv", 64'(sample_valid), 64'd0);
    chk("t6.rst.active", 64'(sweep_active), 64'd0);
    rst = 1'b0; sample_en = 1'b0;
    cyc();
    chk("t6.post.sv", 64'(sample_valid), 64'd0);
    chk("t6.post.valid", 64'(phase_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_nco_phase_gen
